dds_sweep_iq: RTL and testbench
===============================

Name: dds_sweep_iq

Overview:
- Parametrised successor to the single-channel sine DDS.
- Generates phase-continuous quadrature sine/cosine (I/Q) outputs with a programmable phase offset and digital amplitude scaling.
- Includes a built-in stepped-frequency sweep engine (start frequency, step, step count, dwell), so the excitation for impedance spectroscopy runs without per-tone CPU writes.
- Feeds the excitation DAC (I) and the demodulator reference (I and Q).

Parameters:
- FWORD_WIDTH, 28, phase accumulator and frequency word width.
- PWORD_WIDTH, 10, phase offset word width; must be no greater than ADDR_WIDTH.
- ADDR_WIDTH, 12, sine ROM address width; fixed at 12 to match ROM_SIN_12b_4096.
- OUT_WIDTH, 12, sample width; offset-binary, matching the ROM data width.
- AMP_WIDTH, 8, amplitude word width.
- CNT_WIDTH, 16, width of the step-count, step-index and dwell fields.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse that launches a sweep.
- stop  in  1  one-cycle pulse that aborts a sweep.
- f_start  in  FWORD_WIDTH  frequency word of the first tone.
- f_step  in  FWORD_WIDTH  frequency increment per step (modulo 2^FWORD_WIDTH).
- step_count  in  CNT_WIDTH  number of increments; 0 = continuous single tone.
- dwell_cycles  in  CNT_WIDTH  clocks per tone; 0 is treated as 1.
- pha_w  in  PWORD_WIDTH  phase offset applied to both I and Q.
- amp  in  AMP_WIDTH  amplitude scale; full scale = (2^AMP_WIDTH-1)/2^AMP_WIDTH.
- wave_i  out  OUT_WIDTH  sine sample, offset binary.
- wave_q  out  OUT_WIDTH  cosine sample, offset binary.
- valid  out  1  high while wave_i/wave_q carry sweep samples.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse at normal sweep completion.
- step_idx  out  CNT_WIDTH  index of the current tone.

Behaviour:
- Reset (asynchronous, immediate):
  - State = IDLE.
  - Accumulator, frequency register, dwell counter, step_idx and all pipeline registers = 0.
  - wave_i = wave_q = 0; valid = busy = done = 0.
- FSM states: IDLE, RUN.
- IDLE:
  - Accumulator held at 0.
  - On start (and stop low), at that edge E0:
    - Latch f_start into the frequency register.
    - Latch f_step, step_count, dwell_cycles, pha_w and amp.
    - Clear step_idx and the dwell counter.
    - Go to RUN.
  - Inputs are ignored outside this latch edge.
- RUN:
  - Each clock: acc <= acc + freq (mod 2^FWORD_WIDTH). The first post-E0 cycle uses acc = 0.
  - Dwell counter increments each clock. At the terminal count (dwell-1), one of:
    - step_count == 0: counter wraps; tone continues.
    - step_idx == step_count: pulse done; go to IDLE.
    - Otherwise: freq <= freq + f_step (wraps); step_idx++; counter = 0.
  - The accumulator is never cleared on a step, so phase is continuous across tones.
  - start is ignored in RUN.
  - stop in RUN: go to IDLE at the next edge with no done pulse.
  - stop and start together in IDLE: stop wins; stay in IDLE.
  - stop coinciding with the terminal count of the last tone: stop wins; no done pulse.
- Datapath pipeline, 3 stages:
  - S1 address register:
    - a_i = acc[FWORD_WIDTH-1 -: ADDR_WIDTH] + (pha_w << (ADDR_WIDTH-PWORD_WIDTH)), mod 2^ADDR_WIDTH.
    - a_q = a_i + 2^(ADDR_WIDTH-2), mod 2^ADDR_WIDTH (quarter-turn offset).
  - S2: two ROM_SIN_12b_4096 instances, each with 1-cycle read latency.
  - S3 amplitude stage, registered:
    - s = rom XOR MSB (convert to signed).
    - p = (s * amp) >>> AMP_WIDTH, arithmetic shift (truncation toward -inf).
    - out = p XOR MSB (convert back to offset binary).
- Latency and valid:
  - The sample for accumulator value acc(n) appears at wave_i/wave_q 3 clocks later.
  - valid = busy delayed by 3 clocks. It rises at E0+3 and falls 3 clocks after busy falls.
  - While valid is low, wave_i/wave_q are forced to mid-scale 2^(OUT_WIDTH-1). The single exception is reset, which forces 0.
- done is registered, asserted on the edge where the FSM returns to IDLE, and lasts 1 cycle.

Test Plan:
- Reset, then release with no start -> all outputs 0 until the first clock, then wave_i = wave_q = 0x800, valid = 0, busy = 0.
- Continuous tone, default params: f_start = 0x0010000, pha_w = 0, amp = 255, step_count = 0, start at E0 -> valid rises at E0+3; wave_i follows scaled ROM[0], ROM[1], ... one address per clock; wave_q follows ROM[1024], ROM[1025], ...; runs until stop, then valid falls 3 clocks later.
- Sweep: f_start = 0x10000, f_step = 0x10000, step_count = 3, dwell = 10 -> step_idx 0..3 with 10 clocks each; address increment per clock = 1, 2, 3, 4; no accumulator reset between tones; done pulses once at E0+40; busy falls at the same edge.
- Phase and amplitude: pha_w = 256 -> a_i offset = 1024 and wave_i equals the unshifted wave_q. amp = 128 -> ROM peak 0xFFF gives 0xBFF; ROM 0x000 gives 0x400.
- Boundaries:
  - dwell = 0 behaves as 1.
  - f_start = 0xFFFFFFF with f_step = 1 wraps to 0.
  - stop at the last terminal count -> no done.
  - start during RUN -> ignored.
  - start and stop together in IDLE -> stays in IDLE.
  - rst asserted mid-sweep -> outputs 0 immediately; a subsequent start behaves as from E0.

Source files
------------

// File: rtl/ROM_SIN_12b_4096.sv
// 4096-entry, 12-bit offset-binary sine table with one-cycle registered read.
// Contents: parabolic half-wave approximation (peak 0xFFF at 1024, trough 0x000 at 3072).
module ROM_SIN_12b_4096 (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] i_addr,
  output logic [11:0] o_data
);

  logic [11:0] w_x;
  logic [11:0] w_c;
  logic [23:0] w_y;
  logic [34:0] w_ym;
  logic [10:0] w_m;
  logic [11:0] w_data;
  logic [11:0] r_data;

  // Half-wave magnitude: x*(2048-x) peaks at 2^20, scaled to 2047.
  assign w_x    = {1'b0, i_addr[10:0]};
  assign w_c    = 12'd2048 - w_x;
  assign w_y    = 24'(w_x) * 24'(w_c);
  assign w_ym   = 35'(w_y) * 35'd2047;
  assign w_m    = 11'(w_ym >> 20);
  assign w_data = i_addr[11] ? (12'd2047 - {1'b0, w_m}) : (12'd2048 + {1'b0, w_m});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data <= '0;
    end else begin
      r_data <= w_data;
    end
  end

  assign o_data = r_data;

endmodule

// File: rtl/dds_sweep_iq.sv
// Quadrature (I/Q) DDS with phase offset, amplitude scaling and a stepped-frequency sweep engine.
// Three-stage datapath: address register, sine ROM, amplitude scaler.
module dds_sweep_iq #(
  parameter int unsigned FWORD_WIDTH = 28,
  parameter int unsigned PWORD_WIDTH = 10,
  parameter int unsigned ADDR_WIDTH  = 12,
  parameter int unsigned OUT_WIDTH   = 12,
  parameter int unsigned AMP_WIDTH   = 8,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   stop,
  input  logic [FWORD_WIDTH-1:0] f_start,
  input  logic [FWORD_WIDTH-1:0] f_step,
  input  logic [CNT_WIDTH-1:0]   step_count,
  input  logic [CNT_WIDTH-1:0]   dwell_cycles,
  input  logic [PWORD_WIDTH-1:0] pha_w,
  input  logic [AMP_WIDTH-1:0]   amp,
  output logic [OUT_WIDTH-1:0]   wave_i,
  output logic [OUT_WIDTH-1:0]   wave_q,
  output logic                   valid,
  output logic                   busy,
  output logic                   done,
  output logic [CNT_WIDTH-1:0]   step_idx
);

  localparam logic [OUT_WIDTH-1:0]  MidScale    = {1'b1, {(OUT_WIDTH-1){1'b0}}};
  localparam logic [ADDR_WIDTH-1:0] QuarterTurn = ADDR_WIDTH'(1) << (ADDR_WIDTH - 2);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e                 r_state, w_state_d;
  logic [FWORD_WIDTH-1:0] r_acc, w_acc_d;
  logic [FWORD_WIDTH-1:0] r_freq, w_freq_d;
  logic [FWORD_WIDTH-1:0] r_fstep;
  logic [CNT_WIDTH-1:0]   r_count, r_dwell;
  logic [CNT_WIDTH-1:0]   r_cnt, w_cnt_d;
  logic [CNT_WIDTH-1:0]   r_idx, w_idx_d;
  logic [PWORD_WIDTH-1:0] r_pha;
  logic [AMP_WIDTH-1:0]   r_amp;
  logic                   r_done, w_done_d;
  logic                   w_latch;
  logic [CNT_WIDTH-1:0]   w_dwell_m1;
  logic                   w_term;

  // Zero dwell behaves as a one-clock dwell.
  assign w_dwell_m1 = (r_dwell == '0) ? '0 : r_dwell - CNT_WIDTH'(1);
  assign w_term     = (r_cnt == w_dwell_m1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
      r_acc   <= '0;
      r_freq  <= '0;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_acc   <= w_acc_d;
      r_freq  <= w_freq_d;
      r_cnt   <= w_cnt_d;
      r_idx   <= w_idx_d;
      r_done  <= w_done_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fstep <= '0;
      r_count <= '0;
      r_dwell <= '0;
      r_pha   <= '0;
      r_amp   <= '0;
    end else if (w_latch) begin
      r_fstep <= f_step;
      r_count <= step_count;
      r_dwell <= dwell_cycles;
      r_pha   <= pha_w;
      r_amp   <= amp;
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_acc_d   = '0;
    w_freq_d  = r_freq;
    w_cnt_d   = r_cnt;
    w_idx_d   = r_idx;
    w_done_d  = 1'b0;
    w_latch   = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (start && !stop) begin
          w_latch   = 1'b1;
          w_state_d = StRun;
          w_freq_d  = f_start;
          w_cnt_d   = '0;
          w_idx_d   = '0;
        end
      end
      StRun: begin
        // Accumulator never resets on a step, keeping phase continuous across tones.
        w_acc_d = r_acc + r_freq;
        if (stop) begin
          w_state_d = StIdle;
        end else if (w_term) begin
          if (r_count == '0) begin
            w_cnt_d = '0;
          end else if (r_idx == r_count) begin
            w_done_d  = 1'b1;
            w_state_d = StIdle;
          end else begin
            w_freq_d = r_freq + r_fstep;
            w_idx_d  = r_idx + CNT_WIDTH'(1);
            w_cnt_d  = '0;
          end
        end else begin
          w_cnt_d = r_cnt + CNT_WIDTH'(1);
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  logic [ADDR_WIDTH-1:0] w_addr_i, w_addr_q;
  logic [ADDR_WIDTH-1:0] r_addr_i, r_addr_q;
  logic [2:0]            r_vld;
  logic [OUT_WIDTH-1:0]  w_rom_i, w_rom_q;

  assign w_addr_i = r_acc[FWORD_WIDTH-1 -: ADDR_WIDTH]
                  + (ADDR_WIDTH'(r_pha) << (ADDR_WIDTH - PWORD_WIDTH));
  assign w_addr_q = w_addr_i + QuarterTurn;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr_i <= '0;
      r_addr_q <= '0;
      r_vld    <= '0;
    end else begin
      r_addr_i <= w_addr_i;
      r_addr_q <= w_addr_q;
      r_vld    <= {r_vld[1:0], busy};
    end
  end

  ROM_SIN_12b_4096 u_rom_i (
    .clk    (clk),
    .rst    (rst),
    .i_addr (r_addr_i),
    .o_data (w_rom_i)
  );

  ROM_SIN_12b_4096 u_rom_q (
    .clk    (clk),
    .rst    (rst),
    .i_addr (r_addr_q),
    .o_data (w_rom_q)
  );

  logic signed [OUT_WIDTH-1:0]           w_s_i, w_s_q;
  logic signed [AMP_WIDTH:0]             w_amp_s;
  logic signed [OUT_WIDTH+AMP_WIDTH-1:0] w_p_i, w_p_q;
  logic [OUT_WIDTH-1:0]                  w_o_i, w_o_q;
  logic [OUT_WIDTH-1:0]                  r_wave_i, r_wave_q;

  assign w_s_i   = $signed(w_rom_i ^ MidScale);
  assign w_s_q   = $signed(w_rom_q ^ MidScale);
  assign w_amp_s = $signed({1'b0, r_amp});
  assign w_p_i   = (OUT_WIDTH+AMP_WIDTH)'(w_s_i) * (OUT_WIDTH+AMP_WIDTH)'(w_amp_s);
  assign w_p_q   = (OUT_WIDTH+AMP_WIDTH)'(w_s_q) * (OUT_WIDTH+AMP_WIDTH)'(w_amp_s);
  assign w_o_i   = OUT_WIDTH'(w_p_i >>> AMP_WIDTH) ^ MidScale;
  assign w_o_q   = OUT_WIDTH'(w_p_q >>> AMP_WIDTH) ^ MidScale;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wave_i <= '0;
      r_wave_q <= '0;
    end else begin
      r_wave_i <= r_vld[1] ? w_o_i : MidScale;
      r_wave_q <= r_vld[1] ? w_o_q : MidScale;
    end
  end

  assign wave_i   = r_wave_i;
  assign wave_q   = r_wave_q;
  assign valid    = r_vld[2];
  assign busy     = (r_state == StRun);
  assign done     = r_done;
  assign step_idx = r_idx;

endmodule

// File: tb/tb_dds_sweep_iq.sv
// Directed bench for dds_sweep_iq: cycle model of the sweep engine plus hand-computed samples.
module tb_dds_sweep_iq;

  localparam int Mask28 = 'h0FFFFFFF;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        stop;
  logic [27:0] f_start;
  logic [27:0] f_step;
  logic [15:0] step_count;
  logic [15:0] dwell_cycles;
  logic [9:0]  pha_w;
  logic [7:0]  amp;
  logic [11:0] wave_i;
  logic [11:0] wave_q;
  logic        valid;
  logic        busy;
  logic        done;
  logic [15:0] step_idx;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dds_sweep_iq dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .stop         (stop),
    .f_start      (f_start),
    .f_step       (f_step),
    .step_count   (step_count),
    .dwell_cycles (dwell_cycles),
    .pha_w        (pha_w),
    .amp          (amp),
    .wave_i       (wave_i),
    .wave_q       (wave_q),
    .valid        (valid),
    .busy         (busy),
    .done         (done),
    .step_idx     (step_idx)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Sine table: offset 2048, half-wave magnitude 2047*x*(2048-x)/2^20.
  function automatic int rom_model(input int a);
    int x;
    longint y;
    int m;
    x = a % 2048;
    y = longint'(x) * longint'(2048 - x);
    m = int'((y * 2047) / 1048576);
    return (a >= 2048) ? (2047 - m) : (2048 + m);
  endfunction

  function automatic int scale(input int r, input int am);
    int s;
    int p;
    s = r - 2048;
    p = (s * am) >>> 8;
    return p + 2048;
  endfunction

  task automatic run_case(input string name, input int fs, input int fst, input int sc,
                          input int dw, input int pha, input int am, input int ncyc,
                          input int stop_at, input int start_at, input int exp_i0,
                          input int exp_q0);
    int  m_acc, m_freq, m_cnt, m_idx, dm1;
    int  pa1_i, pa1_q, pa2_i, pa2_q, eo_i, eo_q;
    bit  m_busy, m_done, pv1, pv2, ev;
    repeat (4) tick();
    f_start      = fs[27:0];
    f_step       = fst[27:0];
    step_count   = sc[15:0];
    dwell_cycles = dw[15:0];
    pha_w        = pha[9:0];
    amp          = am[7:0];
    start        = 1'b1;
    stop         = 1'b0;
    tick();
    start        = 1'b0;
    // Inputs changed after the latch edge must have no effect.
    f_start      = f_start ^ 28'h5A5A5A5;
    f_step       = f_step + 28'h3;
    step_count   = step_count + 16'd1;
    dwell_cycles = dwell_cycles + 16'd3;
    pha_w        = ~pha_w;
    amp          = ~amp;
    m_busy = 1'b1; m_done = 1'b0; m_idx = 0; m_cnt = 0; m_freq = fs & Mask28; m_acc = 0;
    pv1 = 1'b0; pv2 = 1'b0; pa1_i = 0; pa1_q = 0; pa2_i = 0; pa2_q = 0;
    dm1 = (dw == 0) ? 0 : dw - 1;
    check({name, " E0 busy"}, {31'd0, busy}, 32'd1);
    check({name, " E0 valid"}, {31'd0, valid}, 32'd0);
    check({name, " E0 step_idx"}, {16'd0, step_idx}, 32'd0);
    for (int t = 1; t <= ncyc; t++) begin
      start = (t == start_at);
      stop  = (t == stop_at);
      ev    = pv2;
      eo_i  = pv2 ? scale(rom_model(pa2_i), am) : 2048;
      eo_q  = pv2 ? scale(rom_model(pa2_q), am) : 2048;
      pv2   = pv1;
      pa2_i = pa1_i;
      pa2_q = pa1_q;
      pv1   = m_busy;
      pa1_i = ((m_acc >> 16) + (pha << 2)) & 4095;
      pa1_q = (pa1_i + 1024) & 4095;
      m_done = 1'b0;
      if (m_busy) begin
        bit term;
        term  = (m_cnt == dm1);
        m_acc = (m_acc + m_freq) & Mask28;
        if (stop) begin
          m_busy = 1'b0;
        end else if (term) begin
          if (sc == 0) begin
            m_cnt = 0;
          end else if (m_idx == sc) begin
            m_done = 1'b1;
            m_busy = 1'b0;
          end else begin
            m_freq = (m_freq + fst) & Mask28;
            m_idx++;
            m_cnt = 0;
          end
        end else begin
          m_cnt++;
        end
      end else begin
        m_acc = 0;
      end
      tick();
      check($sformatf("%s t=%0d valid", name, t), {31'd0, valid}, {31'd0, ev});
      check($sformatf("%s t=%0d wave_i", name, t), {20'd0, wave_i}, eo_i);
      check($sformatf("%s t=%0d wave_q", name, t), {20'd0, wave_q}, eo_q);
      check($sformatf("%s t=%0d busy", name, t), {31'd0, busy}, {31'd0, m_busy});
      check($sformatf("%s t=%0d done", name, t), {31'd0, done}, {31'd0, m_done});
      check($sformatf("%s t=%0d step_idx", name, t), {16'd0, step_idx}, m_idx);
      if (t == 3 && exp_i0 >= 0) begin
        check({name, " first wave_i"}, {20'd0, wave_i}, exp_i0);
        check({name, " first wave_q"}, {20'd0, wave_q}, exp_q0);
      end
    end
    start = 1'b0;
    stop  = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0;
    f_start = '0; f_step = '0; step_count = '0; dwell_cycles = '0; pha_w = '0; amp = '0;
    #1;
    check("rst wave_i", {20'd0, wave_i}, 32'd0);
    check("rst wave_q", {20'd0, wave_q}, 32'd0);
    check("rst valid", {31'd0, valid}, 32'd0);
    check("rst busy", {31'd0, busy}, 32'd0);
    check("rst done", {31'd0, done}, 32'd0);
    tick();
    #1 rst = 1'b0;
    tick();
    check("idle wave_i", {20'd0, wave_i}, 32'h800);
    check("idle wave_q", {20'd0, wave_q}, 32'h800);
    check("idle valid", {31'd0, valid}, 32'd0);
    check("idle busy", {31'd0, busy}, 32'd0);

    // name, f_start, f_step, count, dwell, pha, amp, cycles, stop_at, start_at, first I, first Q
    run_case("tone",     'h10000,   0,       0, 5,  0,   255, 30, 24, 10, 'h800, 'hFF7);
    run_case("sweep",    'h10000,   'h10000, 3, 10, 0,   255, 46, 0,  20, 'h800, 'hFF7);
    run_case("pha256",   'h10000,   0,       0, 1,  256, 128, 12, 8,  0,  'hBFF, 'h7FF);
    run_case("pha768",   'h10000,   0,       0, 1,  768, 128, 10, 6,  0,  'h400, 'h800);
    run_case("dwell0",   'h10000,   'h10000, 2, 0,  0,   255, 8,  0,  0,  'h800, 'hFF7);
    run_case("wrap",     'hFFFFFFF, 1,       1, 2,  0,   255, 10, 0,  0,  'h800, 'hFF7);
    run_case("stoplast", 'h10000,   'h20000, 1, 3,  0,   255, 12, 6,  0,  'h800, 'hFF7);

    tick();
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    check("start+stop busy", {31'd0, busy}, 32'd0);
    repeat (3) tick();
    check("start+stop valid", {31'd0, valid}, 32'd0);
    check("start+stop wave_i", {20'd0, wave_i}, 32'h800);

    f_start = 28'h10000; f_step = 28'h10000; step_count = 16'd3; dwell_cycles = 16'd2;
    pha_w = '0; amp = 8'd255;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (7) tick();
    check("pre-rst busy", {31'd0, busy}, 32'd1);
    check("pre-rst step_idx", {16'd0, step_idx}, 32'd3);
    check("pre-rst valid", {31'd0, valid}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("mid-rst wave_i", {20'd0, wave_i}, 32'd0);
    check("mid-rst wave_q", {20'd0, wave_q}, 32'd0);
    check("mid-rst valid", {31'd0, valid}, 32'd0);
    check("mid-rst busy", {31'd0, busy}, 32'd0);
    check("mid-rst step_idx", {16'd0, step_idx}, 32'd0);
    #1 rst = 1'b0;
    run_case("after_rst", 'h10000, 'h10000, 3, 10, 0, 255, 46, 0, 0, 'h800, 'hFF7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
